// File: rtl/disp_scheduler_pkg.sv
// Shared display definitions for the seven-segment scheduler.
//   - Active-low glyph constants and the special digit codes.
//   - Scheduler state enumeration.
package disp_scheduler_pkg;

  localparam logic [6:0] SEG_BLANK  = 7'b1111111;
  localparam logic [6:0] SEG_DASH   = 7'b0111111;
  localparam logic [3:0] CODE_DASH  = 4'd10;
  // Any code from 11 to 15 renders blank; 15 is used internally to force a blank digit.
  localparam logic [3:0] CODE_BLANK = 4'd15;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ALERT_ON  = 2'd1,
    ALERT_OFF = 2'd2
  } disp_state_e;

endpackage

// File: rtl/int_to_7_bit.sv
// Digit code to active-low seven-segment decoder (segment order gfedcba).
// Ports:
//   code  in  4  digit code: 0-9 decimal, 10 dash, 11-15 blank
//   seg   out 7  active-low segment pattern
module int_to_7_bit
  import disp_scheduler_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (code)
      4'd0:      seg = 7'b1000000;
      4'd1:      seg = 7'b1111001;
      4'd2:      seg = 7'b0100100;
      4'd3:      seg = 7'b0110000;
      4'd4:      seg = 7'b0011001;
      4'd5:      seg = 7'b0010010;
      4'd6:      seg = 7'b0000010;
      4'd7:      seg = 7'b1111000;
      4'd8:      seg = 7'b0000000;
      4'd9:      seg = 7'b0010000;
      CODE_DASH: seg = SEG_DASH;
      default:   seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/disp_scheduler.sv
// Chooses what the four-digit seven-segment display shows and generates its refresh strobe.
// Base digits are shown live while idle; an accepted alert takes over the display for a
// fixed number of refresh ticks, optionally blinking.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   base_digits     four live 4-bit codes, digit_0 in [3:0]
//   alert_req       request, held by the requester until alert_ack
//   alert_digits    alert codes, sampled on acceptance
//   alert_blink     blink enable, sampled on acceptance
//   alert_clr       abort the active alert
//   alert_ack       one-cycle acceptance pulse
//   busy            an alert owns the display
//   refresh_tick    one-cycle strobe every REFRESH_DIV clocks
//   seg_0..seg_3    registered active-low segment patterns
module disp_scheduler
  import disp_scheduler_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned HOLD_TICKS  = 2000,
  parameter int unsigned BLINK_TICKS = 250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] base_digits,
  input  logic        alert_req,
  input  logic [15:0] alert_digits,
  input  logic        alert_blink,
  input  logic        alert_clr,
  output logic        alert_ack,
  output logic        busy,
  output logic        refresh_tick,
  output logic [6:0]  seg_0,
  output logic [6:0]  seg_1,
  output logic [6:0]  seg_2,
  output logic [6:0]  seg_3
);

  localparam int unsigned DIV_W   = $clog2(REFRESH_DIV);
  localparam int unsigned HOLD_W  = $clog2(HOLD_TICKS + 1);
  localparam int unsigned BLINK_W = $clog2(BLINK_TICKS + 1);

  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(REFRESH_DIV - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_TICKS);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS);

  // Refresh divider: free-running, never restarted by alert acceptance.
  logic [DIV_W-1:0] div_q;
  logic             tick_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= (div_q == DIV_LAST);
      div_q  <= (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    end
  end

  assign refresh_tick = tick_q;

  // Scheduler state and alert data.
  disp_state_e        state_q, state_d;
  logic [HOLD_W-1:0]  hold_q, hold_d, hold_inc;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d, blink_inc;
  logic [15:0]        alert_dig_q, alert_dig_d;
  logic               alert_blink_q, alert_blink_d;
  logic               accept;
  logic               ack_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      hold_q        <= '0;
      blink_cnt_q   <= '0;
      alert_dig_q   <= '0;
      alert_blink_q <= 1'b0;
      ack_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      blink_cnt_q   <= blink_cnt_d;
      alert_dig_q   <= alert_dig_d;
      alert_blink_q <= alert_blink_d;
      ack_q         <= accept;
    end
  end

  assign hold_inc  = hold_q + HOLD_W'(1);
  assign blink_inc = blink_cnt_q + BLINK_W'(1);

  always_comb begin
    state_d       = state_q;
    hold_d        = hold_q;
    blink_cnt_d   = blink_cnt_q;
    alert_dig_d   = alert_dig_q;
    alert_blink_d = alert_blink_q;
    accept        = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Clear wins over a simultaneous request.
        if (alert_req && !alert_clr) begin
          accept        = 1'b1;
          alert_dig_d   = alert_digits;
          alert_blink_d = alert_blink;
          hold_d        = '0;
          blink_cnt_d   = '0;
          state_d       = ALERT_ON;
        end
      end
      ALERT_ON, ALERT_OFF: begin
        if (alert_clr) begin
          state_d = IDLE;
        end else if (tick_q) begin
          if (hold_inc == HOLD_LAST) begin
            // Expiry wins over a blink toggle due on the same tick.
            hold_d      = '0;
            blink_cnt_d = '0;
            state_d     = IDLE;
          end else begin
            hold_d = hold_inc;
            if (alert_blink_q) begin
              if (blink_inc == BLINK_LAST) begin
                blink_cnt_d = '0;
                state_d     = (state_q == ALERT_ON) ? ALERT_OFF : ALERT_ON;
              end else begin
                blink_cnt_d = blink_inc;
              end
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output selection.
  logic [15:0] disp_codes;

  always_comb begin
    busy       = 1'b0;
    disp_codes = base_digits;
    unique case (state_q)
      IDLE: begin
        busy       = 1'b0;
        disp_codes = base_digits;
      end
      ALERT_ON: begin
        busy       = 1'b1;
        disp_codes = alert_dig_q;
      end
      ALERT_OFF: begin
        busy       = 1'b1;
        disp_codes = {4{CODE_BLANK}};
      end
      default: begin
        busy       = 1'b0;
        disp_codes = {4{CODE_BLANK}};
      end
    endcase
  end

  assign alert_ack = ack_q;

  logic [3:0][6:0] seg_dec;
  logic [3:0][6:0] seg_q;

  for (genvar i = 0; i < 4; i++) begin : g_dec
    int_to_7_bit u_dec (
      .code (disp_codes[i*4 +: 4]),
      .seg  (seg_dec[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q <= {4{SEG_BLANK}};
    end else begin
      seg_q <= seg_dec;
    end
  end

  assign seg_0 = seg_q[0];
  assign seg_1 = seg_q[1];
  assign seg_2 = seg_q[2];
  assign seg_3 = seg_q[3];

endmodule

// File: tb/tb_disp_scheduler.sv
// Self-checking bench for disp_scheduler with a tick/alert-level reference model.
module tb_disp_scheduler;

  localparam int RD = 4;
  localparam int HT = 3;
  localparam int BT = 1;

  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] DASH  = 7'b0111111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] base_digits = 16'h0;
  logic        alert_req = 1'b0;
  logic [15:0] alert_digits = 16'h0;
  logic        alert_blink = 1'b0;
  logic        alert_clr = 1'b0;
  logic        alert_ack, busy, refresh_tick;
  logic [6:0]  seg_0, seg_1, seg_2, seg_3;

  int total = 0;
  int bad   = 0;

  disp_scheduler #(
    .REFRESH_DIV (RD),
    .HOLD_TICKS  (HT),
    .BLINK_TICKS (BT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .base_digits  (base_digits),
    .alert_req    (alert_req),
    .alert_digits (alert_digits),
    .alert_blink  (alert_blink),
    .alert_clr    (alert_clr),
    .alert_ack    (alert_ack),
    .busy         (busy),
    .refresh_tick (refresh_tick),
    .seg_0        (seg_0),
    .seg_1        (seg_1),
    .seg_2        (seg_2),
    .seg_3        (seg_3)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [6:0] glyph(input logic [3:0] c);
    case (c)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      4'd10: return DASH;
      default: return BLANK;
    endcase
  endfunction

  // What the display should show given the alert status; blank phase is every odd
  // blink period counted in elapsed ticks.
  function automatic logic [27:0] view(input logic active, input int ticks, input logic blink,
                                       input logic [15:0] dig, input logic [15:0] base);
    logic [27:0] r;
    logic [3:0]  c;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      if (!active) c = base[i*4 +: 4];
      else if (blink && ((ticks / BT) % 2 == 1)) c = 4'hF;
      else c = dig[i*4 +: 4];
      r[i*7 +: 7] = glyph(c);
    end
    return r;
  endfunction

  int          m_since;
  logic        m_active;
  int          m_ticks;
  logic [15:0] m_dig;
  logic        m_blink;
  logic        exp_ack, exp_tick;
  logic [27:0] exp_seg;

  always @(posedge clk) begin
    if (rst) begin
      m_since  <= 0;
      m_active <= 1'b0;
      m_ticks  <= 0;
      m_dig    <= '0;
      m_blink  <= 1'b0;
      exp_ack  <= 1'b0;
      exp_tick <= 1'b0;
      exp_seg  <= {4{BLANK}};
    end else begin
      exp_seg <= view(m_active, m_ticks, m_blink, m_dig, base_digits);
      exp_ack <= !m_active && alert_req && !alert_clr;
      if (m_active) begin
        if (alert_clr) m_active <= 1'b0;
        else if (exp_tick) begin
          m_ticks <= m_ticks + 1;
          if (m_ticks + 1 == HT) m_active <= 1'b0;
        end
      end else if (alert_req && !alert_clr) begin
        m_active <= 1'b1;
        m_ticks  <= 0;
        m_dig    <= alert_digits;
        m_blink  <= alert_blink;
      end
      m_since  <= m_since + 1;
      exp_tick <= ((m_since + 1) % RD == 0);
    end
  end

  wire [30:0] obs  = {alert_ack, busy, refresh_tick, seg_3, seg_2, seg_1, seg_0};
  wire [30:0] expv = {exp_ack, m_active, exp_tick, exp_seg};
  wire [27:0] segs = {seg_3, seg_2, seg_1, seg_0};

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1;
    base_digits = 16'h3210;
    repeat (2) @(negedge clk);
    total++;
    if (obs !== {3'b000, {4{BLANK}}})
      $display("FAIL reset_values: got=%h want=%h", obs, {3'b000, {4{BLANK}}});
    if (obs !== {3'b000, {4{BLANK}}}) bad++;
    rst = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      total++;
      if (refresh_tick !== (k % RD == 0)) begin
        bad++;
        $display("FAIL tick_cadence k=%0d: got=%b want=%b", k, refresh_tick, (k % RD == 0));
      end
      total++;
      if (obs !== expv) begin
        bad++;
        $display("FAIL reset_model k=%0d: got=%h want=%h", k, obs, expv);
      end
    end
    total++;
    if (segs !== {7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000}) begin
      bad++;
      $display("FAIL base_3210: got=%h want=%h", segs,
               {7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000});
    end
  endtask

  task automatic test_alert(input logic blink);
    int n;
    int nt;
    logic seen_blank;
    alert_req    = 1'b1;
    alert_digits = 16'hAAAA;
    alert_blink  = blink;
    n  = 0;
    nt = 0;
    seen_blank = 1'b0;
    do begin
      @(negedge clk);
      n++;
      total++;
      if (obs !== expv) begin
        bad++;
        $display("FAIL alert_model blink=%b: got=%h want=%h", blink, obs, expv);
      end
    end while (!alert_ack && n < 10);
    total++;
    if (alert_ack !== 1'b1 || busy !== 1'b1 || n !== 1) begin
      bad++;
      $display("FAIL ack_latency blink=%b: ack=%b busy=%b cycles=%0d want 1 1 1",
               blink, alert_ack, busy, n);
    end
    if (refresh_tick) nt++;
    alert_req = 1'b0;
    @(negedge clk);
    total++;
    if (alert_ack !== 1'b0 || segs !== {4{DASH}}) begin
      bad++;
      $display("FAIL ack_pulse_dash blink=%b: ack=%b segs=%h want 0 %h",
               blink, alert_ack, segs, {4{DASH}});
    end
    n = 0;
    while (busy && n < 40) begin
      if (refresh_tick) nt++;
      if (segs === {4{BLANK}}) seen_blank = 1'b1;
      total++;
      if (obs !== expv) begin
        bad++;
        $display("FAIL hold_model blink=%b: got=%h want=%h", blink, obs, expv);
      end
      @(negedge clk);
      n++;
    end
    total++;
    if (busy !== 1'b0 || nt !== HT) begin
      bad++;
      $display("FAIL hold_ticks blink=%b: busy=%b ticks=%0d want 0 %0d", blink, busy, nt, HT);
    end
    total++;
    if (seen_blank !== blink) begin
      bad++;
      $display("FAIL blink_phase: saw_blank=%b want=%b", seen_blank, blink);
    end
    @(negedge clk);
    total++;
    if (segs !== {7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000} || obs !== expv) begin
      bad++;
      $display("FAIL base_return blink=%b: got=%h want=%h", blink, obs, expv);
    end
  endtask

  task automatic test_pending;
    int n;
    int fell;
    int ackc;
    logic ack_while_busy;
    alert_req    = 1'b1;
    alert_digits = 16'h1234;
    alert_blink  = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!alert_ack && n < 10);
    alert_digits = 16'h5555;
    fell = -1;
    ackc = -1;
    ack_while_busy = 1'b0;
    n = 0;
    while (ackc < 0 && n < 60) begin
      @(negedge clk);
      n++;
      total++;
      if (obs !== expv) begin
        bad++;
        $display("FAIL pending_model n=%0d: got=%h want=%h", n, obs, expv);
      end
      if (!busy && fell < 0) fell = n;
      if (alert_ack && fell < 0) ack_while_busy = 1'b1;
      if (alert_ack) ackc = n;
    end
    alert_req = 1'b0;
    total++;
    if (ack_while_busy || fell < 0 || ackc !== fell + 1) begin
      bad++;
      $display("FAIL pending_ack: ack_cycle=%0d busy_fell=%0d early=%b want ack=fell+1",
               ackc, fell, ack_while_busy);
    end
    n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
  endtask

  task automatic test_clr;
    int n;
    base_digits  = 16'h9876;
    alert_req    = 1'b1;
    alert_digits = 16'hAAAA;
    alert_blink  = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!alert_ack && n < 10);
    alert_req = 1'b0;
    alert_clr = 1'b1;
    @(negedge clk);
    alert_clr = 1'b0;
    total++;
    if (busy !== 1'b0 || obs !== expv) begin
      bad++;
      $display("FAIL clr_busy: busy=%b got=%h want=%h", busy, obs, expv);
    end
    @(negedge clk);
    total++;
    if (segs !== {7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010}) begin
      bad++;
      $display("FAIL clr_base: got=%h want=%h", segs,
               {7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010});
    end
    alert_req = 1'b1;
    alert_clr = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (alert_ack !== 1'b0 || busy !== 1'b0 || obs !== expv) begin
        bad++;
        $display("FAIL clr_beats_req k=%0d: ack=%b busy=%b got=%h want=%h",
                 k, alert_ack, busy, obs, expv);
      end
    end
    alert_req = 1'b0;
    alert_clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_rst_mid;
    int n;
    alert_req    = 1'b1;
    alert_digits = 16'h0A0A;
    alert_blink  = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!alert_ack && n < 10);
    alert_req = 1'b0;
    repeat (2) @(negedge clk);
    base_digits = 16'hFBCD;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (obs !== {3'b000, {4{BLANK}}}) begin
      bad++;
      $display("FAIL rst_mid: got=%h want=%h", obs, {3'b000, {4{BLANK}}});
    end
    repeat (2) @(negedge clk);
    total++;
    if (segs !== {4{BLANK}} || busy !== 1'b0 || obs !== expv) begin
      bad++;
      $display("FAIL codes_blank: got=%h want=%h", obs, {3'b000, {4{BLANK}}});
    end
    base_digits = 16'hEDCB;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (segs !== {4{BLANK}}) begin
      bad++;
      $display("FAIL codes_blank2: got=%h want=%h", segs, {4{BLANK}});
    end
  endtask

  task automatic test_random;
    logic holding;
    holding = 1'b0;
    for (int k = 0; k < 900; k++) begin
      @(negedge clk);
      total++;
      if (obs !== expv) begin
        bad++;
        $display("FAIL random k=%0d: got=%h want=%h", k, obs, expv);
      end
      rst = ($urandom % 300 == 0);
      if (rst) begin
        holding   = 1'b0;
        alert_req = 1'b0;
      end else if (holding && alert_ack) begin
        holding   = 1'b0;
        alert_req = 1'b0;
      end else if (!holding && ($urandom % 6 == 0)) begin
        holding      = 1'b1;
        alert_req    = 1'b1;
        alert_digits = 16'($urandom);
        alert_blink  = 1'($urandom);
      end
      alert_clr = ($urandom % 25 == 0);
      if ($urandom % 10 == 0) base_digits = 16'($urandom);
    end
    rst       = 1'b0;
    alert_req = 1'b0;
    alert_clr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_alert(1'b0);
    test_alert(1'b1);
    test_pending();
    test_clr();
    test_rst_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/disp_scheduler.md
# disp_scheduler

Controller that decides what the four-digit seven-segment display shows. It sits in front of `led_display` and has two jobs. First, it divides the system clock into the display refresh strobe. Second, it arbitrates between two content sources: the always-present base digits (for example a score) and a timed alert message that a requester posts through a req/ack handshake. Digit codes are converted to active-low segment patterns before they reach `led_display`, and alerts can optionally blink.

## Interface
- `REFRESH_DIV`, 100000: clk cycles per refresh tick; must be ≥ 2.
- `HOLD_TICKS`, 2000: number of refresh ticks an accepted alert stays active; must be ≥ 1.
- `BLINK_TICKS`, 250: refresh ticks per blink half-period; must be ≥ 1.
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `base_digits`  in  16  four 4-bit codes; bits [3:0] are digit_0 and bits [15:12] are digit_3.
- `alert_req`  in  1  alert request; the requester holds it high until `alert_ack`.
- `alert_digits`  in  16  alert codes, same packing as `base_digits`; sampled when the request is accepted.
- `alert_blink`  in  1  blink enable for this alert; sampled when the request is accepted.
- `alert_clr`  in  1  aborts the active alert.
- `alert_ack`  out  1  one-cycle pulse marking acceptance of a request.
- `busy`  out  1  high while an alert owns the display.
- `refresh_tick`  out  1  one-cycle strobe every `REFRESH_DIV` clks; drives `led_display`'s scan.
- `seg_0`..`seg_3`  out  7 each  active-low segment patterns for `led_display` `digit_0`..`digit_3`.

## Operation
- Code map: 0–9 map to the decimal glyphs; 10 maps to dash 7'b0111111; 11–15 map to blank 7'b1111111.
- The FSM has three states:
  - IDLE: shows the base digits.
  - ALERT_ON: shows the latched alert digits.
  - ALERT_OFF: all four digits blank.
- IDLE with `alert_req`=1 and `alert_clr`=0:
  - latch `alert_digits` and `alert_blink`;
  - clear the hold and blink counters;
  - go to ALERT_ON and pulse `alert_ack`.
- A request while busy is ignored, with no ack; the requester keeps it pending.
- In ALERT_ON or ALERT_OFF, the hold counter increments on each `refresh_tick`. On the tick where it reaches `HOLD_TICKS`, the FSM returns to IDLE.
- If blink is latched, the blink counter also increments on each tick. On the tick where it reaches `BLINK_TICKS`, the counter clears and the state toggles between ALERT_ON and ALERT_OFF. If blink is not latched, the state stays ALERT_ON.
- `alert_clr`=1 in any alert state returns the FSM to IDLE on the next edge, ahead of hold expiry.
- Simultaneous events:
  - `alert_clr` beats `alert_req` in IDLE, so nothing is accepted that cycle.
  - Hold expiry beats a blink toggle on the same tick: the FSM goes to IDLE.
- Base digits are used live in IDLE; they are never latched.

## Timing
- Reset values:
  - outputs: every `seg_x`=7'b1111111, `alert_ack`=0, `busy`=0, `refresh_tick`=0;
  - internal: state IDLE, all counters 0, alert registers 0.
- Refresh divider:
  - counter width $clog2(REFRESH_DIV), counting 0..`REFRESH_DIV`-1 and wrapping;
  - `refresh_tick` is registered and high for the single cycle after the counter's value is `REFRESH_DIV`-1;
  - the first tick therefore arrives `REFRESH_DIV` cycles after reset release.
- Hold and blink counters are `$clog2(param+1)` bits wide and saturate-free, because each is cleared on its terminal tick.
- Acceptance latency: `req` sampled high at edge N gives `alert_ack`=1 and `busy`=1 during cycle N+1 (registered).
- `seg_x` are registered with one cycle of latency from the state and data registers. Alert glyphs therefore appear from cycle N+2.
- `busy` falls in the same cycle the state becomes IDLE; base glyphs return one cycle later.
- The earliest new acceptance is the cycle after `busy` falls.
- Alert duration is `HOLD_TICKS` ticks. The first tick may be partial, because the divider is free-running and is not reset on acceptance.
- `rst` mid-alert: the next edge restores all reset values, the latched alert is dropped, and no ack is issued.

## Structure
- A shared display package holds:
  - the glyph constants (`SEG_BLANK`, `SEG_DASH`, `CODE_DASH`=10);
  - the state enum `{IDLE, ALERT_ON, ALERT_OFF}`.
- One sub-module: four instances of the existing `int_to_7_bit` code-to-segment decoder, one per digit.
- Everything else lives in `disp_scheduler`: divider, FSM, counters, output registers.

## Test plan
All scenarios use `REFRESH_DIV`=4, `HOLD_TICKS`=3, `BLINK_TICKS`=1.

- Reset, then `base_digits`=16'h3210: `refresh_tick` pulses every 4 clks from cycle 4; `seg_0`..`seg_3` show 7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000.
- `alert_req` with `alert_digits`=16'hAAAA and blink off: ack pulses 1 cycle; all segs show 7'b0111111 from N+2; `busy` stays high for 3 ticks; base digits then return.
- Same alert with blink on: segs alternate dash / blank on every tick; the FSM returns to IDLE on the third tick even though a toggle is due.
- A second `alert_req` held during `busy`: no ack until the first alert ends; ack comes on the cycle after `busy` falls.
- `alert_clr` one cycle after ack: `busy` drops next cycle and base glyphs return the cycle after; `alert_clr` and `alert_req` together in IDLE give no ack.
- `rst` asserted mid-alert: all segs 7'b1111111, `busy`=0, `alert_ack`=0 the next cycle; codes 11–15 in `base_digits` show blank.
